// File: rtl/nas_l1_pkg.sv
// Shared defaults and coefficient record for the L1 batch-norm/ReLU/pack path.
package nas_l1_pkg;

  localparam int DEF_WIDTH   = 27;
  localparam int DEF_THREAD  = 2;
  localparam int DEF_CHANNEL = 32;
  localparam int DEF_COEF_W  = 18;
  localparam int DEF_SHIFT   = 14;

  // Matches the {scale, bias} layout of the coefficient write port.
  typedef struct packed {
    logic signed [DEF_COEF_W-1:0] scale;
    logic signed [DEF_COEF_W-1:0] bias;
  } coef_t;

endpackage

// File: rtl/bn_relu_lane.sv
// One lane of the L1 batch-norm path: stage 2 multiply, stage 3 bias/round/shift, ReLU and saturate.
module bn_relu_lane #(
  parameter int IN_WIDTH = 32,
  parameter int WIDTH    = 27,
  parameter int COEF_W   = 18,
  parameter int SHIFT    = 14
) (
  input  logic                       i_sclk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic signed [IN_WIDTH-1:0] i_data,
  input  logic signed [COEF_W-1:0]   i_scale,
  input  logic signed [COEF_W-1:0]   i_bias,
  output logic        [WIDTH-1:0]    o_data
);

  localparam int PW = IN_WIDTH + COEF_W;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] MAX_OUT = (SW'(1) <<< (WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] ROUND   = SW'(1) <<< (SHIFT - 1);

  logic signed [PW-1:0]     prod_q;
  logic signed [COEF_W-1:0] bias_q;
  logic                     valid_q;
  logic signed [SW-1:0]     sum;
  logic signed [SW-1:0]     shifted;
  logic        [WIDTH-1:0]  res;

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prod_q  <= '0;
      bias_q  <= '0;
      valid_q <= 1'b0;
      o_data  <= '0;
    end else begin
      prod_q  <= PW'(i_data) * PW'(i_scale);
      bias_q  <= i_bias;
      valid_q <= i_valid;
      o_data  <= valid_q ? res : '0;
    end
  end

  // SW bits hold the full product plus the shifted bias without overflow.
  always_comb begin
    sum     = SW'(prod_q) + (SW'(bias_q) <<< SHIFT) + ROUND;
    shifted = sum >>> SHIFT;
    res     = shifted[WIDTH-1:0];
    if (shifted < 0)
      res = '0;
    else if (shifted > MAX_OUT)
      res = MAX_OUT[WIDTH-1:0];
  end

endmodule

// File: rtl/bn_relu_pack_l1.sv
// L1 batch-norm + ReLU + pack, 3-cycle fixed latency, per-channel coefficient RAM.
// Define BN_RELU_PACK_L1_ERRCHK_EN to build the line-length checker behind o_err.
module bn_relu_pack_l1
  import nas_l1_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int THREAD     = DEF_THREAD,
  parameter int CHANNEL    = DEF_CHANNEL,
  parameter int LINE_BEATS = 1792,
  parameter int COEF_W     = DEF_COEF_W,
  parameter int SHIFT      = DEF_SHIFT
) (
  input  logic                         i_sclk,
  input  logic                         i_rst_n,
  input  logic                         i_vsync,
  input  logic                         i_hsync,
  input  logic                         i_valid,
  input  logic [IN_WIDTH*THREAD-1:0]   i_tdata,
  input  logic                         i_cwr,
  input  logic [$clog2(CHANNEL)-1:0]   i_caddr,
  input  logic [2*COEF_W-1:0]          i_cdata,
  output logic                         o_vsync,
  output logic                         o_hsync,
  output logic                         o_valid,
  output logic [WIDTH*THREAD-1:0]      o_tdata,
  output logic                         o_err
);

  localparam int CW = $clog2(CHANNEL);

  coef_t                       coef_ram [CHANNEL];
  coef_t                       s1_coef;
  logic [IN_WIDTH*THREAD-1:0]  s1_data;
  logic                        s1_vs, s1_hs, s1_valid;
  logic                        s2_vs, s2_hs, s2_valid;
  logic [CW-1:0]               ch_q, ch_idx, ch_nxt;
  logic                        hsync_q;
  logic                        hs_fall;

  assign hs_fall = hsync_q & ~i_hsync;

  // Channel is forced to 0 on the first hsync-low cycle so that beat already uses channel 0.
  always_comb begin
    ch_idx = (!i_vsync || hs_fall) ? '0 : ch_q;
    ch_nxt = ch_idx;
    if (i_valid)
      ch_nxt = (ch_idx == CW'(CHANNEL - 1)) ? '0 : ch_idx + 1'b1;
  end

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ch_q    <= '0;
      hsync_q <= 1'b0;
    end else begin
      ch_q    <= ch_nxt;
      hsync_q <= i_hsync;
    end
  end

  // No reset on the RAM: coefficients survive a pipeline reset. Same-address read sees the old word.
  always_ff @(posedge i_sclk) begin
    if (i_cwr)
      coef_ram[i_caddr] <= i_cdata;
  end

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_coef  <= '0;
      s1_data  <= '0;
      s1_vs    <= 1'b0;
      s1_hs    <= 1'b0;
      s1_valid <= 1'b0;
      s2_vs    <= 1'b0;
      s2_hs    <= 1'b0;
      s2_valid <= 1'b0;
      o_vsync  <= 1'b0;
      o_hsync  <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      s1_coef  <= coef_ram[ch_idx];
      s1_data  <= i_tdata;
      s1_vs    <= i_vsync;
      s1_hs    <= i_hsync;
      s1_valid <= i_valid;
      s2_vs    <= s1_vs;
      s2_hs    <= s1_hs;
      s2_valid <= s1_valid;
      o_vsync  <= s2_vs;
      o_hsync  <= s2_hs;
      o_valid  <= s2_valid;
    end
  end

  for (genvar k = 0; k < THREAD; k++) begin : g_lane
    bn_relu_lane #(
      .IN_WIDTH (IN_WIDTH),
      .WIDTH    (WIDTH),
      .COEF_W   (COEF_W),
      .SHIFT    (SHIFT)
    ) u_lane (
      .i_sclk   (i_sclk),
      .i_rst_n  (i_rst_n),
      .i_valid  (s1_valid),
      .i_data   (s1_data[k*IN_WIDTH +: IN_WIDTH]),
      .i_scale  (s1_coef.scale),
      .i_bias   (s1_coef.bias),
      .o_data   (o_tdata[k*WIDTH +: WIDTH])
    );
  end

`ifdef BN_RELU_PACK_L1_ERRCHK_EN
  localparam int LW = $clog2(LINE_BEATS + 1) + 1;

  logic [LW-1:0] beat_cnt;
  logic          vsync_q;
  logic          err_q;

  // Counter saturates so an overlong line can never wrap back onto LINE_BEATS.
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_cnt <= '0;
      vsync_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vsync_q <= i_vsync;
      if (hs_fall)
        beat_cnt <= '0;
      else if (i_hsync && i_valid && beat_cnt != '1)
        beat_cnt <= beat_cnt + 1'b1;
      if (i_vsync && !vsync_q)
        err_q <= 1'b0;
      else if ((hs_fall && beat_cnt != LW'(LINE_BEATS)) || (i_valid && !i_hsync))
        err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_bn_relu_pack_l1.sv
// Bench for bn_relu_pack_l1: vector table, line scenarios, reset and RAM collision, with a latency-3 scoreboard.
module tb_bn_relu_pack_l1;

  localparam int IN_WIDTH   = 32;
  localparam int WIDTH      = 27;
  localparam int THREAD     = 2;
  localparam int CHANNEL    = 32;
  localparam int LINE_BEATS = 1792;
  localparam int COEF_W     = 18;
  localparam int SHIFT      = 14;
  localparam logic [26:0] SAT = 27'h3FF_FFFF;
`ifdef BN_RELU_PACK_L1_ERRCHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        i_sclk = 1'b0;
  logic        i_rst_n;
  logic        i_vsync, i_hsync, i_valid, i_cwr;
  logic [63:0] i_tdata;
  logic [4:0]  i_caddr;
  logic [35:0] i_cdata;
  logic        o_vsync, o_hsync, o_valid, o_err;
  logic [53:0] o_tdata;

  always #5 i_sclk = ~i_sclk;

  bn_relu_pack_l1 #(
    .IN_WIDTH(IN_WIDTH), .WIDTH(WIDTH), .THREAD(THREAD), .CHANNEL(CHANNEL),
    .LINE_BEATS(LINE_BEATS), .COEF_W(COEF_W), .SHIFT(SHIFT)
  ) dut (
    .i_sclk(i_sclk), .i_rst_n(i_rst_n), .i_vsync(i_vsync), .i_hsync(i_hsync),
    .i_valid(i_valid), .i_tdata(i_tdata), .i_cwr(i_cwr), .i_caddr(i_caddr),
    .i_cdata(i_cdata), .o_vsync(o_vsync), .o_hsync(o_hsync), .o_valid(o_valid),
    .o_tdata(o_tdata), .o_err(o_err)
  );

  typedef struct {
    logic        vs, hs, v;
    logic [53:0] d;
  } exp_t;

  typedef struct {
    logic signed [17:0] sc, bi;
    logic signed [31:0] l0, l1;
    logic        [26:0] e0, e1;
  } vec_t;

  exp_t               sb_q[$];
  vec_t               vecs[8];
  logic signed [17:0] sc_m[CHANNEL];
  logic signed [17:0] bi_m[CHANNEL];
  int                 m_ch;
  logic               m_hs_q;
  int                 tests = 0;
  int                 fails = 0;

  function automatic logic [26:0] bn(input logic signed [31:0] lane,
                                     input logic signed [17:0] sc,
                                     input logic signed [17:0] bi);
    longint s;
    s = longint'(lane) * longint'(sc) + longint'(bi) * 16384 + 64'sd8192;
    s = s >>> 14;
    if (s < 0) return 27'd0;
    if (s > 64'sd67108863) return SAT;
    return 27'(s);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 3) begin
      e = sb_q.pop_front();
      tests++;
      if ({o_vsync, o_hsync, o_valid, o_tdata} !== {e.vs, e.hs, e.v, e.d}) begin
        fails++;
        $display("FAIL sb @%0t: got vs=%0b hs=%0b v=%0b d=%h, want vs=%0b hs=%0b v=%0b d=%h",
                 $time, o_vsync, o_hsync, o_valid, o_tdata, e.vs, e.hs, e.v, e.d);
      end
    end
  endtask

  // Called at a falling edge: checks the beat driven 3 cycles ago, then drives and predicts this one.
  task automatic drive_cycle(input logic vs, input logic hs, input logic v,
                             input logic signed [31:0] d0, input logic signed [31:0] d1,
                             input logic cwr, input logic [4:0] ca,
                             input logic signed [17:0] csc, input logic signed [17:0] cbi,
                             input logic ovr, input logic [26:0] e0, input logic [26:0] e1);
    exp_t        e;
    int          idx;
    logic [26:0] r0, r1;
    sb_check();
    i_vsync = vs; i_hsync = hs; i_valid = v; i_tdata = {d1, d0};
    i_cwr = cwr; i_caddr = ca; i_cdata = {csc, cbi};
    idx = (!vs || (m_hs_q && !hs)) ? 0 : m_ch;
    r0 = ovr ? e0 : bn(d0, sc_m[idx], bi_m[idx]);
    r1 = ovr ? e1 : bn(d1, sc_m[idx], bi_m[idx]);
    e.vs = vs; e.hs = hs; e.v = v;
    e.d = v ? {r1, r0} : 54'd0;
    sb_q.push_back(e);
    m_ch = v ? ((idx == CHANNEL - 1) ? 0 : idx + 1) : idx;
    m_hs_q = hs;
    if (cwr) begin
      sc_m[ca] = csc;
      bi_m[ca] = cbi;
    end
  endtask

  task automatic step(input logic vs, input logic hs, input logic v,
                      input logic signed [31:0] d0, input logic signed [31:0] d1);
    @(negedge i_sclk);
    drive_cycle(vs, hs, v, d0, d1, 1'b0, 5'd0, 18'sd0, 18'sd0, 1'b0, 27'd0, 27'd0);
  endtask

  task automatic wr(input logic [4:0] ca, input logic signed [17:0] sc, input logic signed [17:0] bi);
    @(negedge i_sclk);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'sd0, 32'sd0, 1'b1, ca, sc, bi, 1'b0, 27'd0, 27'd0);
  endtask

  task automatic line(input int beats);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < beats; i++)
      step(1'b1, 1'b1, 1'b1, 32'(i % 5), -32'(i % 3));
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{18'sd16384,  18'sd0,      32'sd100,         -32'sd5,          27'd100,      27'd0};
    vecs[1] = '{18'sd32768,  18'sd0,      32'sd67108864,    32'sd0,           SAT,          27'd0};
    vecs[2] = '{18'sd16384,  18'sd5,      32'sd7,           -32'sd3,          27'd12,       27'd2};
    vecs[3] = '{18'sd8192,   18'sd0,      32'sd3,           32'sd5,           27'd2,        27'd3};
    vecs[4] = '{-18'sd16384, 18'sd0,      -32'sd100,        32'sd100,         27'd100,      27'd0};
    vecs[5] = '{18'sd16384,  -18'sd10,    32'sd10,          32'sd9,           27'd0,        27'd0};
    vecs[6] = '{18'sd16384,  18'sd0,      32'sd67108863,    32'sd67108864,    27'd67108863, SAT};
    vecs[7] = '{18'sd131071, 18'sd131071, -32'sd2147483648, 32'sd2147483647,  27'd0,        SAT};

    for (int c = 0; c < CHANNEL; c++) begin
      sc_m[c] = '0;
      bi_m[c] = '0;
    end
    m_ch = 0; m_hs_q = 1'b0;
    i_rst_n = 1'b0; i_vsync = 0; i_hsync = 0; i_valid = 0; i_tdata = '0;
    i_cwr = 0; i_caddr = '0; i_cdata = '0;
    repeat (2) @(negedge i_sclk);
    chk("reset_outputs", {8'd0, o_vsync, o_hsync, o_valid, o_err, o_tdata}, 64'd0);
    @(negedge i_sclk);
    i_rst_n = 1'b1;

    for (int n = 0; n < 8; n++) begin
      for (int c = 0; c < CHANNEL; c++)
        wr(5'(c), vecs[n].sc, vecs[n].bi);
      @(negedge i_sclk);
      drive_cycle(1'b1, 1'b1, 1'b1, vecs[n].l0, vecs[n].l1, 1'b0, 5'd0, 18'sd0, 18'sd0,
                  1'b1, vecs[n].e0, vecs[n].e1);
      step(1'b1, 1'b0, 1'b0, 0, 0);
    end

    // Channel c carries bias c; a full-length line must leave o_err clear.
    for (int c = 0; c < CHANNEL; c++)
      wr(5'(c), 18'sd16384, 18'(c));
    line(LINE_BEATS);
    chk("err_full_line", {63'd0, o_err}, 64'd0);

    line(LINE_BEATS - 1);
    chk("err_short_line", {63'd0, o_err}, {63'd0, ERR_EN});
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    chk("err_hold_vs_low", {63'd0, o_err}, {63'd0, ERR_EN});
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    chk("err_clear_vs_rise", {63'd0, o_err}, 64'd0);

    step(1'b1, 1'b0, 1'b1, 32'sd40, 32'sd1);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    chk("err_valid_hs_low", {63'd0, o_err}, {63'd0, ERR_EN});

    // Write channel 3 on the very cycle channel 3 is read.
    step(1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge i_sclk);
      drive_cycle(1'b1, 1'b1, 1'b1, 32'sd0, 32'(i), (i == 3), 5'd3, 18'sd16384, 18'sd1000,
                  1'b0, 27'd0, 27'd0);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0);

    step(1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 32'sd0, 32'sd2);
    #2 i_rst_n = 1'b0;
    #1 chk("midline_reset_async", {8'd0, o_vsync, o_hsync, o_valid, o_err, o_tdata}, 64'd0);
    sb_q.delete();
    m_ch = 0; m_hs_q = 1'b0;
    @(negedge i_sclk);
    chk("midline_reset_hold", {8'd0, o_vsync, o_hsync, o_valid, o_err, o_tdata}, 64'd0);
    @(negedge i_sclk);
    i_rst_n = 1'b1;
    drive_cycle(1'b1, 1'b1, 1'b1, 32'sd0, 32'sd2, 1'b0, 5'd0, 18'sd0, 18'sd0,
                1'b0, 27'd0, 27'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 32'sd0, 32'sd2);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bn_relu_pack_l1.md
BN_RELU_PACK_L1 -- requirements
Module: bn_relu_pack_l1

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- IN_WIDTH, 32, signed conv accumulator width per lane.
- WIDTH, 27, output lane width; matches the downstream L1 maxpool.
- THREAD, 2, lanes per beat.
- CHANNEL, 32, channels cycled per pixel group.
- LINE_BEATS, 1792, valid beats per line (SIZE*CHANNEL/THREAD).
- COEF_W, 18, signed scale and bias width.
- SHIFT, 14, fixed-point fraction bits of scale.
REQ-002 Ports, one per line: name, direction, width, meaning.
- i_sclk, in, 1, single clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_vsync, in, 1, frame active, high for the whole frame.
- i_hsync, in, 1, line active.
- i_valid, in, 1, beat qualifier.
- i_tdata, in, IN_WIDTH*THREAD, lane k at bits [k*IN_WIDTH +: IN_WIDTH].
- i_cwr, in, 1, coefficient write strobe.
- i_caddr, in, $clog2(CHANNEL), coefficient channel index.
- i_cdata, in, 2*COEF_W, {scale, bias}.
- o_vsync, out, 1, aligned frame sync.
- o_hsync, out, 1, aligned line sync.
- o_valid, out, 1, output qualifier.
- o_tdata, out, WIDTH*THREAD, packed lanes.
- o_err, out, 1, sticky line-length error.

Function
REQ-003 Outputs o_vsync, o_hsync, o_valid and o_tdata SHALL equal the input beat's processed result exactly 3 cycles after sampling, with no bubbles and no backpressure.
REQ-004 Stage 1 SHALL register the input and read the coefficient RAM at the current channel index; stage 2 SHALL form the signed product lane*scale; stage 3 SHALL add bias<<<SHIFT plus 1<<(SHIFT-1), arithmetic-shift right by SHIFT, then apply ReLU and saturation.
REQ-005 ReLU and saturation: a negative result SHALL give 0; a result above 2^(WIDTH-1)-1 SHALL give 2^(WIDTH-1)-1; the intermediate SHALL be wide enough (IN_WIDTH+COEF_W+1) that no overflow occurs.
REQ-006 o_tdata SHALL be 0 whenever o_valid is 0.
REQ-007 Channel index SHALL increment on each i_valid and wrap from CHANNEL-1 to 0.
REQ-008 Channel index SHALL clear on the first cycle with i_hsync low, and SHALL be held at 0 while i_vsync is low.
REQ-009 Coefficient RAM SHALL be CHANNEL x 2*COEF_W and written on i_cwr.
REQ-010 When a write and a read hit the same address in the same cycle, the read SHALL return the old value.
REQ-011 Line beat counter SHALL count i_valid while i_hsync is high.
REQ-012 On the i_hsync falling edge the line beat counter SHALL compare against LINE_BEATS and clear.
REQ-013 A mismatch SHALL set o_err, which SHALL stay set until i_vsync rises.
REQ-014 i_valid with i_hsync low SHALL be processed normally but SHALL set o_err.

Reset
REQ-015 While i_rst_n is low, all pipeline registers, counters, o_* and o_err SHALL be 0.
REQ-016 Coefficient RAM contents SHALL be unaffected by reset.
REQ-017 Reset asserted mid-line SHALL drop in-flight beats; the first post-reset beat SHALL use channel 0.

Configuration
REQ-018 With macro BN_RELU_PACK_L1_ERRCHK_EN defined, the line beat counter and o_err logic SHALL be built.
REQ-019 Without BN_RELU_PACK_L1_ERRCHK_EN, o_err SHALL be tied to 0 and the counter SHALL be absent.

Structure
REQ-020 Package nas_l1_pkg SHALL hold the default WIDTH, THREAD, CHANNEL, COEF_W and SHIFT, plus the coef_t struct {scale, bias}.
REQ-021 One sub-module, bn_relu_lane, SHALL implement stages 2-3 for one lane and be instantiated THREAD times via generate.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Scale 1<<14, bias 0, lanes {100,-5} -> o_tdata lanes {100,0} 3 cycles later.
- Scale 2<<14, bias 0, lane 2^26 -> lane saturates to 2^26-1.
- 1792-beat line across 32 channels, channel c with bias c -> output bias pattern repeats every 32 beats; o_err stays 0.
- Line of 1791 beats -> o_err rises after the hsync fall and holds until the next vsync rise.
- i_rst_n pulsed low mid-line -> all outputs go to 0 immediately; the next beat uses channel 0.
- i_cwr to channel 3 on the same cycle channel 3 is read -> old coefficient used; the new one is used from the next pixel group.
